// File: rtl/gsensor_spi_responder.sv
// -----------------------------------------------------------------------------
// gsensor_spi_responder
//   3-wire SPI (mode 3, MSB first) responder emulating the accelerometer side
//   of the G-sensor link. Serves a 64-byte register map: DEVID at 0x00,
//   INT_SOURCE at 0x30, a coherent X/Y/Z snapshot at 0x32-0x37 and plain
//   read/write storage everywhere else.
//
// Ports
//   clk, resetN                 system clock (>= 8x SCLK), async active-low reset
//   spi_csn, spi_sclk           chip select (active low), SPI clock (idles high)
//   spi_sdio_in                 SDIO as seen by the responder
//   spi_sdio_out, spi_sdio_oe   SDIO drive value and output enable
//   sample_x/y/z, sample_valid  new axis samples and their one-cycle strobe
//   int2                        data-ready interrupt
//   wr_strobe, wr_addr, wr_data one pulse per accepted write, last write info
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module gsensor_spi_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_sdio_in,
  output logic        spi_sdio_out,
  output logic        spi_sdio_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        int2,
  output logic        wr_strobe,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR, S_RD} state_e;

  // ---------------- input synchronizers and edge detection ----------------
  logic [SYNC_STAGES-1:0] csn_sync_q, sclk_sync_q, sdio_sync_q;
  logic csn_prev_q, sclk_prev_q;
  logic csn_s, sclk_s, sdio_s;
  logic csn_fall, csn_rise, sclk_rise, sclk_fall;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      csn_sync_q  <= '1;   // bus idle levels: csn high, sclk high
      sclk_sync_q <= '1;
      sdio_sync_q <= '0;
      csn_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b1;
    end else begin
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], spi_sdio_in};
      csn_prev_q  <= csn_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync_q[SYNC_STAGES-1];
  assign csn_fall  =  csn_prev_q & ~csn_s;
  assign csn_rise  = ~csn_prev_q &  csn_s;
  assign sclk_rise = ~sclk_prev_q &  sclk_s;
  assign sclk_fall =  sclk_prev_q & ~sclk_s;

  // ---------------- datapath registers ----------------
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  rx_shift_q;       // the 8th bit comes straight from sdio_s
  logic [7:0]  tx_shift_q;
  logic        oe_q, mb_q, dr_q, wr_strobe_q;
  logic [5:0]  addr_q, wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [15:0] shadow_x_q, shadow_y_q, shadow_z_q;
  logic [15:0] snap_x_q, snap_y_q, snap_z_q;
  logic [7:0]  regs_q [64];

  logic [7:0] rx_byte, rd_data;
  logic [5:0] next_addr;
  logic       last_bit, addr_ro, addr_snap;
  logic       start, cmd_done, wr_done, rd_done, rd_load, rd_shift;

  assign rx_byte   = {rx_shift_q, sdio_s};
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;   // 0x3F wraps to 0x00
  assign addr_snap = (addr_q >= 6'h32) && (addr_q <= 6'h37);
  assign addr_ro   = (addr_q == 6'h00) || (addr_q == 6'h30) || addr_snap;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (csn_rise) state_d = S_IDLE;   // csn rise aborts from any state
    else begin
      case (state_q)
        S_IDLE:  if (csn_fall) state_d = S_CMD;
        S_CMD:   if (sclk_rise && last_bit) state_d = rx_byte[7] ? S_RD : S_WR;
        default: ;
      endcase
    end
  end

  // ---------------- FSM: control decode ----------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    start    = 1'b0;
    cmd_done = 1'b0;
    wr_done  = 1'b0;
    rd_done  = 1'b0;
    rd_load  = 1'b0;
    rd_shift = 1'b0;
    if (!csn_rise) begin
      case (state_q)
        S_IDLE: start    = csn_fall;
        S_CMD:  cmd_done = sclk_rise && last_bit;
        S_WR:   wr_done  = sclk_rise && last_bit;
        S_RD: begin
          rd_load  = sclk_fall && (bit_cnt_q == 3'd0);
          rd_shift = sclk_fall && (bit_cnt_q != 3'd0);
          rd_done  = sclk_rise && last_bit;
        end
        default: ;
      endcase
    end
  end

  // ---------------- register map read mux ----------------
  always_comb begin
    rd_data = regs_q[addr_q];
    case (addr_q)
      6'h00:   rd_data = DEVID;
      6'h30:   rd_data = {dr_q, 7'd0};
      6'h32:   rd_data = snap_x_q[7:0];
      6'h33:   rd_data = snap_x_q[15:8];
      6'h34:   rd_data = snap_y_q[7:0];
      6'h35:   rd_data = snap_y_q[15:8];
      6'h36:   rd_data = snap_z_q[7:0];
      6'h37:   rd_data = snap_z_q[15:8];
      default: ;
    endcase
  end

  // ---------------- transaction datapath ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      oe_q        <= 1'b0;
      mb_q        <= 1'b0;
      addr_q      <= '0;
      dr_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      shadow_x_q  <= '0;
      shadow_y_q  <= '0;
      shadow_z_q  <= '0;
      snap_x_q    <= '0;
      snap_y_q    <= '0;
      snap_z_q    <= '0;
    end else begin
      wr_strobe_q <= 1'b0;

      if (sample_valid) begin
        shadow_x_q <= sample_x;
        shadow_y_q <= sample_y;
        shadow_z_q <= sample_z;
      end

      // Freeze the shadow at transaction start so multi-byte reads are coherent.
      if (start) begin
        snap_x_q  <= shadow_x_q;
        snap_y_q  <= shadow_y_q;
        snap_z_q  <= shadow_z_q;
        bit_cnt_q <= '0;
      end

      if (csn_rise) begin
        bit_cnt_q  <= '0;
        rx_shift_q <= '0;
        oe_q       <= 1'b0;
      end else if (state_q != S_IDLE && sclk_rise) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (state_q != S_RD) rx_shift_q <= rx_byte[6:0];
      end

      if (cmd_done) begin
        addr_q <= rx_byte[5:0];
        mb_q   <= rx_byte[6];
      end

      if (wr_done) begin
        if (!addr_ro) begin
          wr_strobe_q <= 1'b1;
          wr_addr_q   <= addr_q;
          wr_data_q   <= rx_byte;
        end
        addr_q <= next_addr;
      end

      if (rd_load) begin
        tx_shift_q <= rd_data;
        oe_q       <= 1'b1;
      end else if (rd_shift) begin
        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
      end

      if (rd_done) addr_q <= next_addr;

      // A new sample wins over a simultaneous clear by a data-byte read.
      if (sample_valid)             dr_q <= 1'b1;
      else if (rd_done && addr_snap) dr_q <= 1'b0;
    end
  end

  // NOTE: the storage array is reset like any other flop because its
  // power-on contents are architecturally visible (all R/W registers read 0).
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 64; i++) regs_q[i] <= '0;
    end else if (wr_done && !addr_ro) begin
      regs_q[addr_q] <= rx_byte;
    end
  end

  assign spi_sdio_out = tx_shift_q[7];
  assign spi_sdio_oe  = oe_q;
  assign int2         = dr_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;

endmodule
